// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encodings, the default
// wait-timeout, the wait-counter width and a word-alignment helper.
package mem_stage_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_WAIT = 1'b1;

   localparam int unsigned TIMEOUT_DEFAULT = 15;

   // Wide enough for the largest legal TIMEOUT (255).
   localparam int unsigned CNT_W = 8;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst          clock and synchronous active-high reset (clears all)
//   en                load all fields from the *_in inputs
//   bubble            clear the control bits, keep the data fields
//                     (overrides en)
//   *_in              next MEM/WB contents
//   wb_*              registered MEM/WB outputs
module mem_wb_reg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              bubble,
   input  logic              regwrite_in,
   input  logic              memtoreg_in,
   input  logic [DATA_W-1:0] rdata_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [4:0]        wreg_in,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [DATA_W-1:0] wb_rdata,
   output logic [DATA_W-1:0] wb_alu_res,
   output logic [4:0]        wb_wreg
);

   logic              regwrite_q, regwrite_d;
   logic              memtoreg_q, memtoreg_d;
   logic [DATA_W-1:0] rdata_q,    rdata_d;
   logic [DATA_W-1:0] alu_res_q,  alu_res_d;
   logic [4:0]        wreg_q,     wreg_d;

   always_comb begin
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      rdata_d    = rdata_q;
      alu_res_d  = alu_res_q;
      wreg_d     = wreg_q;
      if (bubble) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
      end else if (en) begin
         regwrite_d = regwrite_in;
         memtoreg_d = memtoreg_in;
         rdata_d    = rdata_in;
         alu_res_d  = alu_res_in;
         wreg_d     = wreg_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         rdata_q    <= '0;
         alu_res_q  <= '0;
         wreg_q     <= '0;
      end else begin
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         rdata_q    <= rdata_d;
         alu_res_q  <= alu_res_d;
         wreg_q     <= wreg_d;
      end
   end

   assign wb_regwrite = regwrite_q;
   assign wb_memtoreg = memtoreg_q;
   assign wb_rdata    = rdata_q;
   assign wb_alu_res  = alu_res_q;
   assign wb_wreg     = wreg_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory requests, waits for dm_ack with a
// bounded wait, flags misaligned accesses and timeouts in a sticky mem_err,
// resolves the branch redirect and feeds the MEM/WB register.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   MEM_*                       control/data from the EX/MEM register
//   dm_req/dm_we/dm_addr/dm_wdata  data-memory request (zero when idle)
//   dm_rdata/dm_ack             data-memory response, same-cycle valid
//   PCSrc, pc_br_out            branch redirect to fetch
//   mem_stall                   freeze request for upstream stages
//   mem_err                     sticky misalignment/timeout flag
//   WB_*                        MEM/WB register outputs
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_RegWrite,
   input  logic              MEM_Branch,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              MEM_zero,
   input  logic [DATA_W-1:0] MEM_pc_br,
   input  logic [DATA_W-1:0] MEM_ALU_res,
   input  logic [DATA_W-1:0] MEM_rdata2,
   input  logic [4:0]        MEM_wreg,
   output logic              dm_req,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata,
   input  logic              dm_ack,
   output logic              PCSrc,
   output logic [DATA_W-1:0] pc_br_out,
   output logic              mem_stall,
   output logic              mem_err,
   output logic              WB_RegWrite,
   output logic              WB_MemtoReg,
   output logic [DATA_W-1:0] WB_rdata,
   output logic [DATA_W-1:0] WB_ALU_res,
   output logic [4:0]        WB_wreg
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             err_q,   err_d;

   logic              access;
   logic              is_read;
   logic              aligned;
   logic              req_idle;
   logic              misalign_evt;
   logic              timeout_hit;
   logic              rd_done;
   logic              wb_en;
   logic              wb_bubble;
   logic [DATA_W-1:0] wb_rdata_in;

   // A simultaneous read+write is treated as a write; the read is dropped.
   assign access  = MEM_MemRead | MEM_MemWrite;
   assign is_read = MEM_MemRead & ~MEM_MemWrite;
   assign aligned = word_aligned(MEM_ALU_res[1:0]);

   assign req_idle     = (state_q == ST_IDLE) & access & aligned;
   assign misalign_evt = (state_q == ST_IDLE) & access & ~aligned;
   // The WAIT cycle in which the counter would reach TIMEOUT is the last one.
   assign timeout_hit  = (state_q == ST_WAIT) & ~dm_ack &
                         ((cnt_q + 1'b1) == TIMEOUT_CNT);

   assign dm_req    = req_idle | (state_q == ST_WAIT);
   assign dm_we     = dm_req & MEM_MemWrite;
   assign dm_addr   = dm_req ? MEM_ALU_res : '0;
   assign dm_wdata  = dm_req ? MEM_rdata2  : '0;
   assign mem_stall = dm_req & ~dm_ack;

   assign PCSrc     = MEM_Branch & MEM_zero;
   assign pc_br_out = MEM_pc_br;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q | misalign_evt | timeout_hit;
      case (state_q)
         ST_IDLE: begin
            if (req_idle && !dm_ack) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (dm_ack || timeout_hit) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign mem_err = err_q;

   assign rd_done     = dm_req & dm_ack & is_read;
   assign wb_rdata_in = rd_done ? dm_rdata : '0;
   assign wb_en       = ~mem_stall;
   // timeout_hit is already a stall edge; listed for clarity of intent.
   assign wb_bubble   = mem_stall | misalign_evt | timeout_hit;

   mem_wb_reg #(
      .DATA_W (DATA_W)
   ) u_mem_wb_reg (
      .clk         (clk),
      .rst         (rst),
      .en          (wb_en),
      .bubble      (wb_bubble),
      .regwrite_in (MEM_RegWrite),
      .memtoreg_in (is_read),
      .rdata_in    (wb_rdata_in),
      .alu_res_in  (MEM_ALU_res),
      .wreg_in     (MEM_wreg),
      .wb_regwrite (WB_RegWrite),
      .wb_memtoreg (WB_MemtoReg),
      .wb_rdata    (WB_rdata),
      .wb_alu_res  (WB_ALU_res),
      .wb_wreg     (WB_wreg)
   );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_zero;
   logic [31:0] MEM_pc_br, MEM_ALU_res, MEM_rdata2;
   logic [4:0]  MEM_wreg;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ack;
   logic        PCSrc;
   logic [31:0] pc_br_out;
   logic        mem_stall, mem_err;
   logic        WB_RegWrite, WB_MemtoReg;
   logic [31:0] WB_rdata, WB_ALU_res;
   logic [4:0]  WB_wreg;

   always #5 clk = ~clk;

   mem_stage #(
      .DATA_W  (32),
      .TIMEOUT (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .MEM_RegWrite (MEM_RegWrite),
      .MEM_Branch   (MEM_Branch),
      .MEM_MemRead  (MEM_MemRead),
      .MEM_MemWrite (MEM_MemWrite),
      .MEM_zero     (MEM_zero),
      .MEM_pc_br    (MEM_pc_br),
      .MEM_ALU_res  (MEM_ALU_res),
      .MEM_rdata2   (MEM_rdata2),
      .MEM_wreg     (MEM_wreg),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ack       (dm_ack),
      .PCSrc        (PCSrc),
      .pc_br_out    (pc_br_out),
      .mem_stall    (mem_stall),
      .mem_err      (mem_err),
      .WB_RegWrite  (WB_RegWrite),
      .WB_MemtoReg  (WB_MemtoReg),
      .WB_rdata     (WB_rdata),
      .WB_ALU_res   (WB_ALU_res),
      .WB_wreg      (WB_wreg)
   );

   typedef struct {
      logic [4:0]  wreg;
      logic        memtoreg;
      logic [31:0] rdata;
      logic [31:0] alu;
   } wb_exp_t;

   wb_exp_t sb_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] wreg, input logic memtoreg,
                           input logic [31:0] rdata, input logic [31:0] alu);
      wb_exp_t e;
      e.wreg = wreg; e.memtoreg = memtoreg; e.rdata = rdata; e.alu = alu;
      sb_q.push_back(e);
   endtask

   // Monitor: every cycle the MEM/WB register shows RegWrite=1 is one retired
   // instruction and must match the oldest queued expectation.
   initial begin
      wb_exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (WB_RegWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_retire got wreg=%0d rdata=0x%08h exp=none",
                        WB_wreg, WB_rdata);
            end else begin
               e = sb_q.pop_front();
               chk("retire_wreg",     32'(WB_wreg),     32'(e.wreg));
               chk("retire_memtoreg", 32'(WB_MemtoReg), 32'(e.memtoreg));
               chk("retire_rdata",    WB_rdata,         e.rdata);
               chk("retire_alu_res",  WB_ALU_res,       e.alu);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      MEM_RegWrite = 1'b0; MEM_Branch = 1'b0; MEM_MemRead = 1'b0;
      MEM_MemWrite = 1'b0; MEM_zero = 1'b0;
      MEM_pc_br = '0; MEM_ALU_res = '0; MEM_rdata2 = '0; MEM_wreg = '0;
      dm_ack = 1'b0; dm_rdata = '0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg);
      idle_inputs();
      MEM_MemRead = rd; MEM_MemWrite = wr; MEM_RegWrite = rw;
      MEM_ALU_res = addr; MEM_rdata2 = wdata; MEM_wreg = wreg;
   endtask

   int req_cycles;
   logic to_seen;

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      settle();
      chk("rst_wb_regwrite", 32'(WB_RegWrite), 0);
      chk("rst_wb_memtoreg", 32'(WB_MemtoReg), 0);
      chk("rst_wb_rdata",    WB_rdata, 0);
      chk("rst_wb_alu_res",  WB_ALU_res, 0);
      chk("rst_mem_err",     32'(mem_err), 0);
      chk("rst_dm_req",      32'(dm_req), 0);

      // Zero-wait load
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd5);
      dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
      push_exp(5'd5, 1'b1, 32'hDEADBEEF, 32'h100);
      settle();
      chk("zw_dm_req",  32'(dm_req), 1);
      chk("zw_stall",   32'(mem_stall), 0);
      chk("zw_dm_addr", dm_addr, 32'h100);
      chk("zw_dm_we",   32'(dm_we), 0);

      // 3-wait store (RegWrite set so the bubble during the stall is visible)
      cyc();
      drive(1'b0, 1'b1, 1'b1, 32'h204, 32'h12345678, 5'd9);
      settle();
      chk("zw_wb_memtoreg", 32'(WB_MemtoReg), 1);
      chk("st_dm_we",    32'(dm_we), 1);
      chk("st_dm_wdata", dm_wdata, 32'h12345678);
      chk("st_stall0",   32'(mem_stall), 1);
      for (int i = 1; i < 3; i++) begin
         cyc();
         settle();
         chk("st_stall",       32'(mem_stall), 1);
         chk("st_dm_we_wait",  32'(dm_we), 1);
         chk("st_wb_regwrite", 32'(WB_RegWrite), 0);
         chk("st_wb_rdata_hold", WB_rdata, 32'hDEADBEEF);
      end
      cyc();
      dm_ack = 1'b1;
      push_exp(5'd9, 1'b0, 32'h0, 32'h204);
      settle();
      chk("st_release", 32'(mem_stall), 0);

      // 2-wait load
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd12);
      settle();
      chk("ld2_stall0", 32'(mem_stall), 1);
      cyc();
      settle();
      chk("ld2_stall1", 32'(mem_stall), 1);
      chk("ld2_bubble", 32'(WB_RegWrite), 0);
      cyc();
      dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
      push_exp(5'd12, 1'b1, 32'hCAFEF00D, 32'h300);
      settle();
      chk("ld2_release", 32'(mem_stall), 0);

      // Branch resolution
      cyc();
      idle_inputs();
      MEM_Branch = 1'b1; MEM_zero = 1'b1; MEM_pc_br = 32'h40;
      settle();
      chk("br_pcsrc_taken", 32'(PCSrc), 1);
      chk("br_pc_br_out",   pc_br_out, 32'h40);
      chk("br_no_req",      32'(dm_req), 0);
      cyc();
      MEM_zero = 1'b0;
      settle();
      chk("br_pcsrc_not_taken", 32'(PCSrc), 0);

      // Timeout: read never acknowledged
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd3);
      settle();
      chk("to_err_before", 32'(mem_err), 0);
      req_cycles = 0;
      to_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (dm_req) req_cycles++;
         cyc();
         if (mem_err) begin
            to_seen = 1'b1;
            idle_inputs();
            break;
         end
         settle();
      end
      chk("to_seen",       32'(to_seen), 1);
      chk("to_req_cycles", 32'(req_cycles), 16);
      settle();
      chk("to_idle_no_req", 32'(dm_req), 0);
      chk("to_bubble",      32'(WB_RegWrite), 0);
      chk("to_stall_off",   32'(mem_stall), 0);

      // Zero-wait load after timeout
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h10C, 32'h0, 5'd20);
      dm_ack = 1'b1; dm_rdata = 32'hA5A50F0F;
      push_exp(5'd20, 1'b1, 32'hA5A50F0F, 32'h10C);
      settle();
      chk("pt_stall", 32'(mem_stall), 0);

      // Reset during WAIT, followed by a late ack
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 5'd21);
      settle();
      chk("rw_stall0", 32'(mem_stall), 1);
      cyc();
      settle();
      chk("rw_wait1_req", 32'(dm_req), 1);
      cyc();
      settle();
      chk("rw_wait2_req", 32'(dm_req), 1);
      rst = 1'b1;
      idle_inputs();
      cyc();
      rst = 1'b0;
      dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
      settle();
      chk("rw_dm_req",      32'(dm_req), 0);
      chk("rw_stall",       32'(mem_stall), 0);
      chk("rw_mem_err",     32'(mem_err), 0);
      chk("rw_wb_regwrite", 32'(WB_RegWrite), 0);
      chk("rw_wb_memtoreg", 32'(WB_MemtoReg), 0);
      chk("rw_wb_rdata",    WB_rdata, 0);
      chk("rw_wb_alu_res",  WB_ALU_res, 0);
      chk("rw_wb_wreg",     32'(WB_wreg), 0);
      cyc();
      dm_ack = 1'b0;
      settle();
      chk("rw_late_ack_rdata", WB_rdata, 0);
      chk("rw_late_ack_req",   32'(dm_req), 0);

      // Misaligned load
      cyc();
      drive(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd7);
      settle();
      chk("mis_no_req",   32'(dm_req), 0);
      chk("mis_no_stall", 32'(mem_stall), 0);
      chk("mis_err_pre",  32'(mem_err), 0);
      cyc();
      idle_inputs();
      settle();
      chk("mis_err",        32'(mem_err), 1);
      chk("mis_bubble",     32'(WB_RegWrite), 0);
      chk("mis_alu_hold",   WB_ALU_res, 0);

      // Read and write both set: treated as a write
      cyc();
      drive(1'b1, 1'b1, 1'b1, 32'h600, 32'h55AA55AA, 5'd30);
      dm_ack = 1'b1; dm_rdata = 32'h11111111;
      push_exp(5'd30, 1'b0, 32'h0, 32'h600);
      settle();
      chk("rw_both_we",    32'(dm_we), 1);
      chk("rw_both_stall", 32'(mem_stall), 0);
      cyc();
      idle_inputs();
      settle();
      chk("err_sticky", 32'(mem_err), 1);

      repeat (3) cyc();
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, width of data, address, ALU result and branch-target buses.
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles without dm_ack before abort (1..255).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_zero  in  1 each  control bits from the EX/MEM register.
REQ-006 MEM_pc_br, MEM_ALU_res, MEM_rdata2  in  DATA_W each  branch target, ALU result/address, store data.
REQ-007 MEM_wreg  in  5  destination register number.
REQ-008 dm_req, dm_we  out  1 each  data-memory request and write-enable; dm_addr, dm_wdata  out  DATA_W.
REQ-009 dm_rdata  in  DATA_W, dm_ack  in  1  read data and completion, valid in the same cycle.
REQ-010 PCSrc  out  1, pc_br_out  out  DATA_W  branch redirect to fetch.
REQ-011 mem_stall  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM.
REQ-012 mem_err  out  1  sticky error flag.
REQ-013 WB_RegWrite, WB_MemtoReg  out  1 each; WB_rdata, WB_ALU_res  out  DATA_W; WB_wreg  out  5  MEM/WB register outputs.

Function
REQ-014 Access = MEM_MemRead | MEM_MemWrite; when both are set, the access is a write and the read is suppressed.
REQ-015 FSM states: IDLE, WAIT; IDLE->WAIT when access, address aligned, no dm_ack; WAIT->IDLE on dm_ack or timeout.
REQ-016 dm_req is combinational: high in IDLE with aligned access, and throughout WAIT; otherwise 0.
REQ-017 dm_addr = MEM_ALU_res, dm_wdata = MEM_rdata2, dm_we = MEM_MemWrite while dm_req=1; all 0 otherwise.
REQ-018 Zero-wait access: dm_ack in the IDLE request cycle completes it with no stall and no WAIT entry.
REQ-019 mem_stall = dm_req & ~dm_ack (combinational); EX/MEM inputs are held stable by upstream while mem_stall=1.
REQ-020 dm_ack while dm_req=0 is ignored.
REQ-021 Misaligned access (MEM_ALU_res[1:0] != 0): no dm_req, no stall, mem_err set next edge, MEM/WB gets a bubble.
REQ-022 Wait counter clears on entering WAIT and increments each WAIT cycle without ack; reaching TIMEOUT sets mem_err, returns to IDLE, and forces a bubble.
REQ-023 mem_err stays 1 until rst.
REQ-024 MEM/WB update on each non-stall edge: WB_RegWrite<=MEM_RegWrite, WB_MemtoReg<=MEM_MemRead&~MEM_MemWrite, WB_ALU_res<=MEM_ALU_res, WB_wreg<=MEM_wreg, WB_rdata<=dm_rdata on a completing read, else 0.
REQ-025 On stall edges, and on error/timeout edges, WB_RegWrite<=0 and WB_MemtoReg<=0 (bubble); data fields hold.
REQ-026 PCSrc = MEM_Branch & MEM_zero and pc_br_out = MEM_pc_br (combinational, same cycle).
REQ-027 Latency: a zero-wait load reaches WB_rdata one edge after the request cycle; an N-wait load N+1 edges after.

Reset
REQ-028 rst (sync): state<=IDLE, counter<=0, mem_err<=0, all WB_* outputs <=0; dm_req=0 in the following cycle.
REQ-029 rst asserted in WAIT aborts the access; a late dm_ack after reset is ignored.

Structure
REQ-030 The shared package/header holds the state encodings (IDLE=0, WAIT=1) and the default TIMEOUT value.
REQ-031 The MEM/WB register is the single sub-module mem_wb_reg, with bubble and enable inputs.

Verification
REQ-032 Zero-wait load: addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next edge WB_rdata=0xDEADBEEF, WB_MemtoReg=1.
REQ-033 3-wait store: addr 0x204, wdata 0x12345678 -> mem_stall=1 for 3 cycles, dm_we=1, WB_RegWrite=0 during stall; released on ack.
REQ-034 Timeout: read with no ack, TIMEOUT=15 -> dm_req high 16 cycles, then mem_err=1, IDLE, bubble.
REQ-035 Misaligned: MemRead with addr 0x102 -> dm_req never 1, mem_err=1 next edge, WB_RegWrite=0.
REQ-036 Branch: MEM_Branch=1, MEM_zero=1, pc_br=0x40 -> PCSrc=1, pc_br_out=0x40 same cycle; zero=0 -> PCSrc=0.
REQ-037 Reset in WAIT after 2 cycles -> dm_req=0 next cycle, mem_err=0, WB_* all 0; ack one cycle later ignored.
